fp_execute_stage2: RTL and testbench
====================================

Name: fp_execute_stage2

Overview:
Second stage of the floating point pipeline. It consumes the registered outputs of fp_execute_stage1 and produces registered outputs for fp_execute_stage3.
- Addition/conversion path: aligns the smaller-exponent significand by right shift and extracts guard/round/sticky bits.
- Multiplication path: forms the full 64-bit significand product.
- All other per-lane flags, and the instruction context, are registered through unchanged.
- Entries belonging to a thread that writeback is rolling back are squashed.

Parameters:
NUM_LANES, 16, number of vector lanes (equals NUM_VECTOR_LANES).

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
wb_rollback_en  in  1  rollback request from writeback_stage
wb_rollback_thread_idx  in  local_thread_idx_t  thread being rolled back
fx1_instruction_valid  in  1  stage-1 entry valid
fx1_instruction  in  decoded_instruction_t  decoded instruction
fx1_mask_value  in  vector_mask_t  lane mask
fx1_thread_idx  in  local_thread_idx_t  issuing thread
fx1_subcycle  in  subcycle_t  subcycle
fx1_result_inf, fx1_result_nan, fx1_equal  in  NUM_LANES each  per-lane flags
fx1_ftoi_lshift  in  NUM_LANES x 6  ftoi left shift
fx1_significand_le, fx1_significand_se  in  NUM_LANES x 32  add-path significands
fx1_se_align_shift  in  NUM_LANES x 6  right shift amount, range 0..32
fx1_add_exponent  in  NUM_LANES x 8  add-path exponent
fx1_logical_subtract, fx1_add_result_sign  in  NUM_LANES each  add-path control
fx1_multiplicand, fx1_multiplier  in  NUM_LANES x 32  multiply operands
fx1_mul_exponent  in  NUM_LANES x 8  multiply exponent
fx1_mul_underflow, fx1_mul_sign  in  NUM_LANES each  multiply flags
fx2_instruction_valid  out  1  entry valid to stage 3
fx2_instruction, fx2_mask_value, fx2_thread_idx, fx2_subcycle  out  same types  registered context
fx2_result_inf, fx2_result_nan, fx2_equal, fx2_ftoi_lshift  out  as inputs  registered pass-through
fx2_significand_le  out  NUM_LANES x 32  registered pass-through
fx2_aligned_se  out  NUM_LANES x 32  significand_se >> se_align_shift
fx2_guard, fx2_round, fx2_sticky  out  NUM_LANES each  rounding bits
fx2_add_exponent, fx2_logical_subtract, fx2_add_result_sign  out  registered pass-through
fx2_significand_product  out  NUM_LANES x 64  unsigned multiplicand*multiplier
fx2_mul_exponent, fx2_mul_underflow, fx2_mul_sign  out  registered pass-through

Behaviour:
- Latency: exactly 1 cycle for every output. No backpressure and no stall input.
- Reset (reset==0 at a rising edge): every output register goes to 0, including context and datapath. Reset takes priority over all other inputs. Deasserting reset mid-stream loses any in-flight entry; the first valid output appears 1 cycle after the first sampled valid input.
- Valid register: fx2_instruction_valid <= fx1_instruction_valid && !(wb_rollback_en && wb_rollback_thread_idx == fx1_thread_idx).
- A rollback for a different thread does not affect the entry.
- Context and datapath registers load every non-reset cycle regardless of valid. Their contents are don't-care when valid is 0.
- Alignment, with s = fx1_se_align_shift and x = fx1_significand_se:
  - aligned_se = x >> s.
  - guard = x[s-1] if s ≥ 1, else 0.
  - round = x[s-2] if s ≥ 2, else 0.
  - sticky = OR(x[s-3:0]) if s ≥ 3, else 0.
  - s = 32: aligned_se = 0, guard = x[31], round = x[30], sticky = OR(x[29:0]).
  - s > 32 is illegal; the bench asserts it never occurs.
- Product: full 64-bit unsigned product, no truncation. A zero operand gives a zero product.
- Pass-through fields are bit-exact copies, with no modification.

Test Plan:
- reset=0 for 2 cycles with fx1_instruction_valid=1 → all outputs 0. Release → first valid appears 1 cycle after the next valid input.
- Valid input, thread 2, rollback_en=1, rollback thread 2 → fx2_instruction_valid=0. Same with rollback thread 3 → valid=1 and all fields copied.
- se=0x00FFFFFF, s=4 → aligned 0x000FFFFF, guard=1, round=1, sticky=1. se=0x00800000, s=24 → aligned 0, guard=1, round=0, sticky=0.
- s=0 and se=0x00C00000 → aligned 0x00C00000, guard/round/sticky=0. s=32 with se=0x80000001 → aligned 0, guard=1, round=0, sticky=1.
- multiplicand=0x00800000, multiplier=0x00C00000 → product 0x0000600000000000. Operands 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE00000001.
- Back-to-back valid inputs from 4 threads over 4 cycles with random lane data → outputs match a reference model 1 cycle later, with no bubbles.

Source files
------------

// File: rtl/fp_execute_stage2.sv
// Floating point pipeline stage 2: aligns the smaller add-path significand with
// guard/round/sticky extraction and forms the full multiply significand product.
module fp_execute_stage2 #(
  parameter int unsigned NUM_LANES    = 16,
  parameter int unsigned INSTR_W      = 64,
  parameter int unsigned THREAD_IDX_W = 2,
  parameter int unsigned SUBCYCLE_W   = 4,
  localparam int unsigned SIG_W       = 32,
  localparam int unsigned SHIFT_W     = 6,
  localparam int unsigned EXP_W       = 8,
  localparam int unsigned PROD_W      = 2 * SIG_W
) (
  input  logic                                  clk,
  input  logic                                  reset,

  input  logic                                  wb_rollback_en,
  input  logic [THREAD_IDX_W-1:0]               wb_rollback_thread_idx,

  input  logic                                  fx1_instruction_valid,
  input  logic [INSTR_W-1:0]                    fx1_instruction,
  input  logic [NUM_LANES-1:0]                  fx1_mask_value,
  input  logic [THREAD_IDX_W-1:0]               fx1_thread_idx,
  input  logic [SUBCYCLE_W-1:0]                 fx1_subcycle,
  input  logic [NUM_LANES-1:0]                  fx1_result_inf,
  input  logic [NUM_LANES-1:0]                  fx1_result_nan,
  input  logic [NUM_LANES-1:0]                  fx1_equal,
  input  logic [NUM_LANES-1:0][SHIFT_W-1:0]     fx1_ftoi_lshift,
  input  logic [NUM_LANES-1:0][SIG_W-1:0]       fx1_significand_le,
  input  logic [NUM_LANES-1:0][SIG_W-1:0]       fx1_significand_se,
  input  logic [NUM_LANES-1:0][SHIFT_W-1:0]     fx1_se_align_shift,
  input  logic [NUM_LANES-1:0][EXP_W-1:0]       fx1_add_exponent,
  input  logic [NUM_LANES-1:0]                  fx1_logical_subtract,
  input  logic [NUM_LANES-1:0]                  fx1_add_result_sign,
  input  logic [NUM_LANES-1:0][SIG_W-1:0]       fx1_multiplicand,
  input  logic [NUM_LANES-1:0][SIG_W-1:0]       fx1_multiplier,
  input  logic [NUM_LANES-1:0][EXP_W-1:0]       fx1_mul_exponent,
  input  logic [NUM_LANES-1:0]                  fx1_mul_underflow,
  input  logic [NUM_LANES-1:0]                  fx1_mul_sign,

  output logic                                  fx2_instruction_valid,
  output logic [INSTR_W-1:0]                    fx2_instruction,
  output logic [NUM_LANES-1:0]                  fx2_mask_value,
  output logic [THREAD_IDX_W-1:0]               fx2_thread_idx,
  output logic [SUBCYCLE_W-1:0]                 fx2_subcycle,
  output logic [NUM_LANES-1:0]                  fx2_result_inf,
  output logic [NUM_LANES-1:0]                  fx2_result_nan,
  output logic [NUM_LANES-1:0]                  fx2_equal,
  output logic [NUM_LANES-1:0][SHIFT_W-1:0]     fx2_ftoi_lshift,
  output logic [NUM_LANES-1:0][SIG_W-1:0]       fx2_significand_le,
  output logic [NUM_LANES-1:0][SIG_W-1:0]       fx2_aligned_se,
  output logic [NUM_LANES-1:0]                  fx2_guard,
  output logic [NUM_LANES-1:0]                  fx2_round,
  output logic [NUM_LANES-1:0]                  fx2_sticky,
  output logic [NUM_LANES-1:0][EXP_W-1:0]       fx2_add_exponent,
  output logic [NUM_LANES-1:0]                  fx2_logical_subtract,
  output logic [NUM_LANES-1:0]                  fx2_add_result_sign,
  output logic [NUM_LANES-1:0][PROD_W-1:0]      fx2_significand_product,
  output logic [NUM_LANES-1:0][EXP_W-1:0]       fx2_mul_exponent,
  output logic [NUM_LANES-1:0]                  fx2_mul_underflow,
  output logic [NUM_LANES-1:0]                  fx2_mul_sign
);

  logic                               rollback_hit_c;
  logic [NUM_LANES-1:0][SIG_W-1:0]    aligned_se_c;
  logic [NUM_LANES-1:0]               guard_c;
  logic [NUM_LANES-1:0]               round_c;
  logic [NUM_LANES-1:0]               sticky_c;
  logic [NUM_LANES-1:0][PROD_W-1:0]   product_c;

  // Squash entries owned by the thread writeback is rolling back.
  assign rollback_hit_c = wb_rollback_en && (wb_rollback_thread_idx == fx1_thread_idx);

  for (genvar lane = 0; lane < NUM_LANES; lane++) begin : g_lane
    logic [2*SIG_W-1:0] shifted_c;

    // Shifting {x, 0} keeps the bits shifted out of x in the low half, so
    // guard/round/sticky fall out at fixed positions for any s in 0..32.
    always_comb begin
      shifted_c = {fx1_significand_se[lane], SIG_W'(0)} >> fx1_se_align_shift[lane];
    end

    assign aligned_se_c[lane] = shifted_c[2*SIG_W-1:SIG_W];
    assign guard_c[lane]      = shifted_c[SIG_W-1];
    assign round_c[lane]      = shifted_c[SIG_W-2];
    assign sticky_c[lane]     = |shifted_c[SIG_W-3:0];
    assign product_c[lane]    = PROD_W'(fx1_multiplicand[lane]) * PROD_W'(fx1_multiplier[lane]);
  end

  // Context and datapath load every cycle; only the valid bit is qualified.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fx2_instruction_valid   <= 1'b0;
      fx2_instruction         <= '0;
      fx2_mask_value          <= '0;
      fx2_thread_idx          <= '0;
      fx2_subcycle            <= '0;
      fx2_result_inf          <= '0;
      fx2_result_nan          <= '0;
      fx2_equal               <= '0;
      fx2_ftoi_lshift         <= '0;
      fx2_significand_le      <= '0;
      fx2_aligned_se          <= '0;
      fx2_guard               <= '0;
      fx2_round               <= '0;
      fx2_sticky              <= '0;
      fx2_add_exponent        <= '0;
      fx2_logical_subtract    <= '0;
      fx2_add_result_sign     <= '0;
      fx2_significand_product <= '0;
      fx2_mul_exponent        <= '0;
      fx2_mul_underflow       <= '0;
      fx2_mul_sign            <= '0;
    end else begin
      fx2_instruction_valid   <= fx1_instruction_valid && !rollback_hit_c;
      fx2_instruction         <= fx1_instruction;
      fx2_mask_value          <= fx1_mask_value;
      fx2_thread_idx          <= fx1_thread_idx;
      fx2_subcycle            <= fx1_subcycle;
      fx2_result_inf          <= fx1_result_inf;
      fx2_result_nan          <= fx1_result_nan;
      fx2_equal               <= fx1_equal;
      fx2_ftoi_lshift         <= fx1_ftoi_lshift;
      fx2_significand_le      <= fx1_significand_le;
      fx2_aligned_se          <= aligned_se_c;
      fx2_guard               <= guard_c;
      fx2_round               <= round_c;
      fx2_sticky              <= sticky_c;
      fx2_add_exponent        <= fx1_add_exponent;
      fx2_logical_subtract    <= fx1_logical_subtract;
      fx2_add_result_sign     <= fx1_add_result_sign;
      fx2_significand_product <= product_c;
      fx2_mul_exponent        <= fx1_mul_exponent;
      fx2_mul_underflow       <= fx1_mul_underflow;
      fx2_mul_sign            <= fx1_mul_sign;
    end
  end

endmodule

// File: tb/tb_fp_execute_stage2.sv
// Self-checking bench for fp_execute_stage2: arithmetic reference model checked
// every cycle, plus hand-computed literal checks on directed vectors.
module tb_fp_execute_stage2;
  localparam int unsigned NL = 16;
  localparam int unsigned IW = 64;
  localparam int unsigned TW = 2;
  localparam int unsigned SW = 4;

  logic clk = 1'b0;
  logic reset;
  logic wb_rollback_en;
  logic [TW-1:0] wb_rollback_thread_idx;
  logic fx1_instruction_valid;
  logic [IW-1:0] fx1_instruction;
  logic [NL-1:0] fx1_mask_value;
  logic [TW-1:0] fx1_thread_idx;
  logic [SW-1:0] fx1_subcycle;
  logic [NL-1:0] fx1_result_inf, fx1_result_nan, fx1_equal;
  logic [NL-1:0][5:0] fx1_ftoi_lshift, fx1_se_align_shift;
  logic [NL-1:0][31:0] fx1_significand_le, fx1_significand_se, fx1_multiplicand, fx1_multiplier;
  logic [NL-1:0][7:0] fx1_add_exponent, fx1_mul_exponent;
  logic [NL-1:0] fx1_logical_subtract, fx1_add_result_sign, fx1_mul_underflow, fx1_mul_sign;

  logic fx2_instruction_valid;
  logic [IW-1:0] fx2_instruction;
  logic [NL-1:0] fx2_mask_value;
  logic [TW-1:0] fx2_thread_idx;
  logic [SW-1:0] fx2_subcycle;
  logic [NL-1:0] fx2_result_inf, fx2_result_nan, fx2_equal;
  logic [NL-1:0][5:0] fx2_ftoi_lshift;
  logic [NL-1:0][31:0] fx2_significand_le, fx2_aligned_se;
  logic [NL-1:0] fx2_guard, fx2_round, fx2_sticky;
  logic [NL-1:0][7:0] fx2_add_exponent, fx2_mul_exponent;
  logic [NL-1:0] fx2_logical_subtract, fx2_add_result_sign, fx2_mul_underflow, fx2_mul_sign;
  logic [NL-1:0][63:0] fx2_significand_product;

  fp_execute_stage2 #(.NUM_LANES(NL), .INSTR_W(IW), .THREAD_IDX_W(TW), .SUBCYCLE_W(SW)) dut (
    .clk(clk), .reset(reset),
    .wb_rollback_en(wb_rollback_en), .wb_rollback_thread_idx(wb_rollback_thread_idx),
    .fx1_instruction_valid(fx1_instruction_valid), .fx1_instruction(fx1_instruction),
    .fx1_mask_value(fx1_mask_value), .fx1_thread_idx(fx1_thread_idx), .fx1_subcycle(fx1_subcycle),
    .fx1_result_inf(fx1_result_inf), .fx1_result_nan(fx1_result_nan), .fx1_equal(fx1_equal),
    .fx1_ftoi_lshift(fx1_ftoi_lshift), .fx1_significand_le(fx1_significand_le),
    .fx1_significand_se(fx1_significand_se), .fx1_se_align_shift(fx1_se_align_shift),
    .fx1_add_exponent(fx1_add_exponent), .fx1_logical_subtract(fx1_logical_subtract),
    .fx1_add_result_sign(fx1_add_result_sign), .fx1_multiplicand(fx1_multiplicand),
    .fx1_multiplier(fx1_multiplier), .fx1_mul_exponent(fx1_mul_exponent),
    .fx1_mul_underflow(fx1_mul_underflow), .fx1_mul_sign(fx1_mul_sign),
    .fx2_instruction_valid(fx2_instruction_valid), .fx2_instruction(fx2_instruction),
    .fx2_mask_value(fx2_mask_value), .fx2_thread_idx(fx2_thread_idx), .fx2_subcycle(fx2_subcycle),
    .fx2_result_inf(fx2_result_inf), .fx2_result_nan(fx2_result_nan), .fx2_equal(fx2_equal),
    .fx2_ftoi_lshift(fx2_ftoi_lshift), .fx2_significand_le(fx2_significand_le),
    .fx2_aligned_se(fx2_aligned_se), .fx2_guard(fx2_guard), .fx2_round(fx2_round),
    .fx2_sticky(fx2_sticky), .fx2_add_exponent(fx2_add_exponent),
    .fx2_logical_subtract(fx2_logical_subtract), .fx2_add_result_sign(fx2_add_result_sign),
    .fx2_significand_product(fx2_significand_product), .fx2_mul_exponent(fx2_mul_exponent),
    .fx2_mul_underflow(fx2_mul_underflow), .fx2_mul_sign(fx2_mul_sign)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int lane, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lane %0d: got 0x%0h expected 0x%0h at %0t", name, lane, act, exp, $time);
    end
  endtask

  // Reference model: what the stage must present after each rising edge.
  logic exp_check = 1'b0;
  logic exp_zero;
  logic exp_valid;
  logic [IW-1:0] exp_instr;
  logic [NL-1:0] exp_mask;
  logic [TW-1:0] exp_thread;
  logic [SW-1:0] exp_sub;
  logic [NL-1:0] exp_inf, exp_nan, exp_eq, exp_lsub, exp_asign, exp_uflow, exp_msign;
  logic [NL-1:0] exp_guard, exp_round, exp_sticky;
  logic [NL-1:0][5:0] exp_lshift;
  logic [NL-1:0][31:0] exp_le, exp_aligned;
  logic [NL-1:0][7:0] exp_aexp, exp_mexp;
  logic [NL-1:0][63:0] exp_prod;

  always @(posedge clk) begin
    exp_check = 1'b1;
    if (!reset) begin
      exp_zero = 1'b1;
      exp_valid = 1'b0;
      exp_instr = '0; exp_mask = '0; exp_thread = '0; exp_sub = '0;
      exp_inf = '0; exp_nan = '0; exp_eq = '0; exp_lsub = '0; exp_asign = '0;
      exp_uflow = '0; exp_msign = '0; exp_guard = '0; exp_round = '0; exp_sticky = '0;
      exp_lshift = '0; exp_le = '0; exp_aligned = '0; exp_aexp = '0; exp_mexp = '0; exp_prod = '0;
    end else begin
      exp_zero = 1'b0;
      exp_valid = fx1_instruction_valid &&
                  !(wb_rollback_en && wb_rollback_thread_idx == fx1_thread_idx);
      exp_instr = fx1_instruction; exp_mask = fx1_mask_value;
      exp_thread = fx1_thread_idx; exp_sub = fx1_subcycle;
      exp_inf = fx1_result_inf; exp_nan = fx1_result_nan; exp_eq = fx1_equal;
      exp_lshift = fx1_ftoi_lshift; exp_le = fx1_significand_le;
      exp_aexp = fx1_add_exponent; exp_lsub = fx1_logical_subtract; exp_asign = fx1_add_result_sign;
      exp_mexp = fx1_mul_exponent; exp_uflow = fx1_mul_underflow; exp_msign = fx1_mul_sign;
      for (int i = 0; i < NL; i++) begin
        int s;
        logic [31:0] x;
        logic st;
        s = int'(fx1_se_align_shift[i]);
        x = fx1_significand_se[i];
        chk("shift_legal", i, 64'(s <= 32), 64'd1);
        exp_aligned[i] = (s >= 32) ? 32'd0 : (x >> s);
        exp_guard[i] = (s >= 1) ? x[s-1] : 1'b0;
        exp_round[i] = (s >= 2) ? x[s-2] : 1'b0;
        st = 1'b0;
        for (int j = 0; j < s - 2; j++) st = st | x[j];
        exp_sticky[i] = st;
        exp_prod[i] = 64'(fx1_multiplicand[i]) * 64'(fx1_multiplier[i]);
      end
    end
  end

  // Compare process: valid every cycle, payload whenever it is meaningful.
  always @(negedge clk) begin
    if (exp_check) begin
      chk("valid", 0, 64'(fx2_instruction_valid), 64'(exp_valid));
      if (exp_valid || exp_zero) begin
        chk("instruction", 0, fx2_instruction, exp_instr);
        chk("mask", 0, 64'(fx2_mask_value), 64'(exp_mask));
        chk("thread", 0, 64'(fx2_thread_idx), 64'(exp_thread));
        chk("subcycle", 0, 64'(fx2_subcycle), 64'(exp_sub));
        for (int i = 0; i < NL; i++) begin
          chk("flags", i, {58'd0, fx2_result_inf[i], fx2_result_nan[i], fx2_equal[i],
                           fx2_logical_subtract[i], fx2_add_result_sign[i], fx2_mul_sign[i]},
                          {58'd0, exp_inf[i], exp_nan[i], exp_eq[i],
                           exp_lsub[i], exp_asign[i], exp_msign[i]});
          chk("mul_underflow", i, 64'(fx2_mul_underflow[i]), 64'(exp_uflow[i]));
          chk("ftoi_lshift", i, 64'(fx2_ftoi_lshift[i]), 64'(exp_lshift[i]));
          chk("significand_le", i, 64'(fx2_significand_le[i]), 64'(exp_le[i]));
          chk("aligned_se", i, 64'(fx2_aligned_se[i]), 64'(exp_aligned[i]));
          chk("grs", i, {61'd0, fx2_guard[i], fx2_round[i], fx2_sticky[i]},
                        {61'd0, exp_guard[i], exp_round[i], exp_sticky[i]});
          chk("exponents", i, {48'd0, fx2_add_exponent[i], fx2_mul_exponent[i]},
                              {48'd0, exp_aexp[i], exp_mexp[i]});
          chk("product", i, fx2_significand_product[i], exp_prod[i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic randomize_data();
    fx1_instruction = {$urandom, $urandom};
    fx1_mask_value = NL'($urandom);
    fx1_subcycle = SW'($urandom);
    fx1_result_inf = NL'($urandom); fx1_result_nan = NL'($urandom); fx1_equal = NL'($urandom);
    fx1_logical_subtract = NL'($urandom); fx1_add_result_sign = NL'($urandom);
    fx1_mul_underflow = NL'($urandom); fx1_mul_sign = NL'($urandom);
    for (int i = 0; i < NL; i++) begin
      fx1_ftoi_lshift[i] = 6'($urandom);
      fx1_significand_le[i] = $urandom;
      fx1_significand_se[i] = $urandom;
      fx1_se_align_shift[i] = 6'($urandom_range(0, 32));
      fx1_add_exponent[i] = 8'($urandom);
      fx1_multiplicand[i] = $urandom;
      fx1_multiplier[i] = $urandom;
      fx1_mul_exponent[i] = 8'($urandom);
    end
  endtask

  task automatic set_ctx(input logic v, input int thr, input logic rb, input int rbt);
    fx1_instruction_valid = v;
    fx1_thread_idx = TW'(thr);
    wb_rollback_en = rb;
    wb_rollback_thread_idx = TW'(rbt);
  endtask

  initial begin
    reset = 1'b0;
    randomize_data();
    set_ctx(1'b1, 1, 1'b0, 0);
    tick();
    randomize_data();
    tick();
    chk("lit_reset_valid", 0, 64'(fx2_instruction_valid), 64'd0);
    chk("lit_reset_prod", 0, fx2_significand_product[0], 64'd0);
    chk("lit_reset_instr", 0, fx2_instruction, 64'd0);

    reset = 1'b1;
    randomize_data();
    set_ctx(1'b0, 1, 1'b0, 0);
    tick();
    chk("lit_idle_valid", 0, 64'(fx2_instruction_valid), 64'd0);
    randomize_data();
    set_ctx(1'b1, 1, 1'b0, 0);
    tick();
    chk("lit_first_valid", 0, 64'(fx2_instruction_valid), 64'd1);

    // Rollback of the same thread squashes; a different thread passes.
    randomize_data();
    set_ctx(1'b1, 2, 1'b1, 2);
    tick();
    chk("lit_rollback_same", 0, 64'(fx2_instruction_valid), 64'd0);
    randomize_data();
    set_ctx(1'b1, 2, 1'b1, 3);
    tick();
    chk("lit_rollback_other", 0, 64'(fx2_instruction_valid), 64'd1);
    chk("lit_rollback_thread", 0, 64'(fx2_thread_idx), 64'd2);

    // Directed alignment and product corners.
    randomize_data();
    set_ctx(1'b1, 0, 1'b0, 0);
    fx1_significand_se[0] = 32'h00FF_FFFF; fx1_se_align_shift[0] = 6'd4;
    fx1_significand_se[1] = 32'h0080_0000; fx1_se_align_shift[1] = 6'd24;
    fx1_significand_se[2] = 32'h00C0_0000; fx1_se_align_shift[2] = 6'd0;
    fx1_significand_se[3] = 32'h8000_0001; fx1_se_align_shift[3] = 6'd32;
    fx1_multiplicand[0] = 32'h0080_0000; fx1_multiplier[0] = 32'h00C0_0000;
    fx1_multiplicand[1] = 32'hFFFF_FFFF; fx1_multiplier[1] = 32'hFFFF_FFFF;
    fx1_multiplicand[2] = 32'd0;         fx1_multiplier[2] = 32'h1234_5678;
    tick();
    chk("lit_align_s4", 0, 64'(fx2_aligned_se[0]), 64'h000F_FFFF);
    chk("lit_grs_s4", 0, {61'd0, fx2_guard[0], fx2_round[0], fx2_sticky[0]}, 64'b111);
    chk("lit_align_s24", 1, 64'(fx2_aligned_se[1]), 64'd0);
    chk("lit_grs_s24", 1, {61'd0, fx2_guard[1], fx2_round[1], fx2_sticky[1]}, 64'b100);
    chk("lit_align_s0", 2, 64'(fx2_aligned_se[2]), 64'h00C0_0000);
    chk("lit_grs_s0", 2, {61'd0, fx2_guard[2], fx2_round[2], fx2_sticky[2]}, 64'b000);
    chk("lit_align_s32", 3, 64'(fx2_aligned_se[3]), 64'd0);
    chk("lit_grs_s32", 3, {61'd0, fx2_guard[3], fx2_round[3], fx2_sticky[3]}, 64'b101);
    chk("lit_prod_a", 0, fx2_significand_product[0], 64'h0000_6000_0000_0000);
    chk("lit_prod_max", 1, fx2_significand_product[1], 64'hFFFF_FFFE_0000_0001);
    chk("lit_prod_zero", 2, fx2_significand_product[2], 64'd0);

    // Back-to-back entries from four threads: no bubbles.
    for (int t = 0; t < 4; t++) begin
      randomize_data();
      set_ctx(1'b1, t, 1'b0, 0);
      tick();
      if (t > 0) chk("lit_b2b_valid", t, 64'(fx2_instruction_valid), 64'd1);
    end
    tick();
    chk("lit_b2b_last_thread", 0, 64'(fx2_thread_idx), 64'd3);

    // Random traffic with random rollbacks.
    for (int k = 0; k < 12; k++) begin
      randomize_data();
      set_ctx(1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 3)));
      tick();
    end

    // Mid-stream reset drops the in-flight entry.
    randomize_data();
    set_ctx(1'b1, 1, 1'b0, 0);
    reset = 1'b0;
    tick();
    chk("lit_midreset_valid", 0, 64'(fx2_instruction_valid), 64'd0);
    reset = 1'b1;
    randomize_data();
    tick();
    chk("lit_after_reset_valid", 0, 64'(fx2_instruction_valid), 64'd1);

    set_ctx(1'b0, 0, 1'b0, 0);
    tick();
    tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
